serial_rx: RTL

UART receiver that turns the asynchronous serial line from the host into parallel bytes for the message printer: each validated byte appears on `data` with a one-cycle `new_data` strobe. Its outputs connect directly to the printer's `rx_data` / `new_rx_data` inputs, which is how host commands such as "h" and "a" reach the debug logic. The format is 8N1, LSB first, line idle high. Framing errors are flagged, not delivered.

---
 rtl/serial_rx.sv | 125 ++++++++++++
 1 files changed

// File: rtl/serial_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver: double-flop synchronizer, mid-bit sampling FSM,
// one-cycle strobes for good bytes and framing errors.
module serial_rx #(
   parameter int CLK_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       new_data,
   output logic       frame_err,
   output logic       busy
);

   localparam int HALF = CLK_PER_BIT / 2;
   localparam int CW   = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0] CTR_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CTR_LAST = CW'(CLK_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_t;

   logic          rx_m;
   logic          rx_s;
   state_t        state;
   logic [CW-1:0] ctr;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ctr       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         data      <= '0;
         new_data  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         new_data  <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               ctr <= '0;
               if (!rx_s) begin
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (ctr == CTR_HALF) begin
                  ctr <= '0;
                  if (!rx_s) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  ctr <= ctr + 1'b1;
               end
            end
            DATA: begin
               if (ctr == CTR_LAST) begin
                  ctr   <= '0;
                  // LSB arrives first, so shift in from the top
                  shreg <= {rx_s, shreg[7:1]};
                  if (bit_idx == 3'd7) state <= STOP;
                  else bit_idx <= bit_idx + 1'b1;
               end else begin
                  ctr <= ctr + 1'b1;
               end
            end
            STOP: begin
               if (ctr == CTR_LAST) begin
                  ctr <= '0;
                  if (rx_s) begin
                     data     <= shreg;
                     new_data <= 1'b1;
                     state    <= IDLE;
                     busy     <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= BRK;
                  end
               end else begin
                  ctr <= ctr + 1'b1;
               end
            end
            BRK: begin
               // held-low line must not look like a fresh start bit
               ctr <= '0;
               if (rx_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               ctr   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
